// File: rtl/dmem_mmio.sv
// dmem_mmio
// Data-side memory responder for the pipelined RISC-V core's Memory stage.
// It holds a word-addressed data RAM plus a small memory-mapped peripheral
// set: a GPIO output register, a free-running cycle counter, a compare timer
// with a sticky flag, and a byte transmit FIFO drained over valid/ready.
//
// Address map (word address = ALUResultM[31:2]):
//   0x0000_0000 .. RAM_WORDS*4-1 : data RAM
//   0x8000_0000 GPIO        read/write
//   0x8000_0004 CYCLE       read-only, writes ignored
//   0x8000_0008 TIMER_CMP   read/write
//   0x8000_000C STATUS      bit0 timer flag (W1C), bit1 full, bit2 empty,
//                           bits[5:3] count, bit6 overflow (W1C)
//   0x8000_0010 TX_DATA     write pushes WriteDataM[7:0], reads return 0
//   anything else           reads 0, writes ignored
//
// Ports:
//   clk         clock, rising edge
//   reset       synchronous active-high reset (RAM is not reset)
//   MemWriteM   store strobe from the M stage
//   ALUResultM  byte address, bits [1:0] ignored
//   WriteDataM  store data
//   ReadDataM   load data, combinational from the address
//   gpio_out    GPIO register value
//   timer_irq   timer flag
//   tx_data     FIFO head byte, 0 when empty
//   tx_valid    FIFO not empty
//   tx_ready    consumer accepts the head byte
module dmem_mmio #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic [31:0] gpio_out,
  output logic        timer_irq,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int RamAw = $clog2(RAM_WORDS);
  localparam int PtrW  = $clog2(FIFO_DEPTH);
  localparam logic [2:0] DepthCount = 3'(FIFO_DEPTH);

  localparam logic [29:0] WaGpio   = 30'h2000_0000;
  localparam logic [29:0] WaCycle  = 30'h2000_0001;
  localparam logic [29:0] WaCmp    = 30'h2000_0002;
  localparam logic [29:0] WaStatus = 30'h2000_0003;
  localparam logic [29:0] WaTxData = 30'h2000_0004;

  logic [29:0]      wordAddr;
  logic             isRam;
  logic [RamAw-1:0] ramIdx;
  logic             unusedAddrBits;

  logic [31:0] ram [RAM_WORDS];

  logic [31:0] cycleCount;
  logic [31:0] timerCmp;
  logic        timerFlag;
  logic        overflow;

  logic [7:0]      fifoMem [FIFO_DEPTH];
  logic [PtrW-1:0] rdPtr;
  logic [PtrW-1:0] wrPtr;
  logic [2:0]      count;
  logic            fifoFull;
  logic            fifoEmpty;
  logic            pushReq;
  logic            pushOk;
  logic            pop;

  logic        gpioWr;
  logic        cmpWr;
  logic        statusWr;
  logic        ramWr;
  logic [31:0] statusWord;

  // Address decode. RAM occupies the bottom of the map, so any set bit above
  // the RAM index pushes the access out of RAM (no aliasing into low words).
  assign wordAddr       = ALUResultM[31:2];
  assign isRam          = (ALUResultM[31:RamAw+2] == '0);
  assign ramIdx         = ALUResultM[RamAw+1:2];
  assign unusedAddrBits = ^ALUResultM[1:0];

  assign ramWr    = MemWriteM && isRam;
  assign gpioWr   = MemWriteM && (wordAddr == WaGpio);
  assign cmpWr    = MemWriteM && (wordAddr == WaCmp);
  assign statusWr = MemWriteM && (wordAddr == WaStatus);
  assign pushReq  = MemWriteM && (wordAddr == WaTxData);

  // FIFO handshake. A push into a full FIFO is still accepted when the head
  // leaves in the same cycle, because the slot it vacates is reused.
  assign fifoFull  = (count == DepthCount);
  assign fifoEmpty = (count == 3'd0);
  assign pop       = !fifoEmpty && tx_ready;
  assign pushOk    = pushReq && (!fifoFull || pop);

  assign tx_valid  = !fifoEmpty;
  assign tx_data   = fifoEmpty ? 8'h00 : fifoMem[rdPtr];
  assign timer_irq = timerFlag;

  assign statusWord = {25'd0, overflow, count, fifoEmpty, fifoFull, timerFlag};

  // Data RAM: no reset, contents survive a mid-run reset.
  always_ff @(posedge clk) begin
    if (ramWr) begin
      ram[ramIdx] <= WriteDataM;
    end
  end

  // Load path. Registers are read before the edge, so a same-cycle store or
  // counter tick is never visible until the following cycle.
  always_comb begin
    ReadDataM = 32'd0;
    if (isRam) begin
      ReadDataM = ram[ramIdx];
    end else begin
      case (wordAddr)
        WaGpio:   ReadDataM = gpio_out;
        WaCycle:  ReadDataM = cycleCount;
        WaCmp:    ReadDataM = timerCmp;
        WaStatus: ReadDataM = statusWord;
        default:  ReadDataM = 32'd0;
      endcase
    end
  end

  // Peripheral registers. For both sticky flags the set condition is tested
  // first so a set arriving with a W1C in the same cycle wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_out   <= 32'd0;
      cycleCount <= 32'd0;
      timerCmp   <= 32'hFFFF_FFFF;
      timerFlag  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      cycleCount <= cycleCount + 32'd1;
      if (gpioWr) begin
        gpio_out <= WriteDataM;
      end
      if (cmpWr) begin
        timerCmp <= WriteDataM;
      end
      if (cycleCount == timerCmp) begin
        timerFlag <= 1'b1;
      end else if (statusWr && WriteDataM[0]) begin
        timerFlag <= 1'b0;
      end
      if (pushReq && !pushOk) begin
        overflow <= 1'b1;
      end else if (statusWr && WriteDataM[6]) begin
        overflow <= 1'b0;
      end
    end
  end

  // FIFO storage has no reset; emptiness is tracked by count alone.
  always_ff @(posedge clk) begin
    if (pushOk) begin
      fifoMem[wrPtr] <= WriteDataM[7:0];
    end
  end

  // FIFO pointers and occupancy. Depth is a power of two so the pointers
  // wrap naturally; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= 3'd0;
    end else begin
      if (pushOk) begin
        wrPtr <= wrPtr + PtrW'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PtrW'(1);
      end
      case ({pushOk, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio
// Directed self-checking bench for dmem_mmio. Inputs change 1-2 ns after the
// rising edge and outputs are compared before the next edge, so every check
// sees the pre-edge state of the cycle it is in.
module tb_dmem_mmio;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWriteM = 1'b0;
  logic [31:0] ALUResultM = 32'd0;
  logic [31:0] WriteDataM = 32'd0;
  logic [31:0] ReadDataM;
  logic [31:0] gpio_out;
  logic        timer_irq;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  localparam logic [31:0] AGpio   = 32'h8000_0000;
  localparam logic [31:0] ACycle  = 32'h8000_0004;
  localparam logic [31:0] ACmp    = 32'h8000_0008;
  localparam logic [31:0] AStatus = 32'h8000_000C;
  localparam logic [31:0] ATx     = 32'h8000_0010;

  dmem_mmio #(.RAM_WORDS(64), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWriteM  (MemWriteM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .gpio_out   (gpio_out),
    .timer_irq  (timer_irq),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Advance past the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Drive one request for the current cycle and let it settle
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] data);
    MemWriteM  = we;
    ALUResultM = addr;
    WriteDataM = data;
    #1;
  endtask

  // Synchronous reset pulse; leaves the bench at cycle 0
  task automatic doReset();
    reset = 1'b1;
    MemWriteM = 1'b0;
    tx_ready = 1'b0;
    ALUResultM = 32'd0;
    step();
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    doReset();
    checks++; if (gpio_out !== 32'd0) begin errors++; $display("[TB] FAIL reset_gpio: got %h expected %h", gpio_out, 32'd0); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_tx_data: got %h expected 00", tx_data); end
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: got %b expected 0", timer_irq); end
    applyStimulus(1'b0, ACmp, 32'd0);
    checks++; if (ReadDataM !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL reset_cmp: got %h expected ffffffff", ReadDataM); end
    applyStimulus(1'b0, AStatus, 32'd0);
    checks++; if (ReadDataM !== 32'h0000_0004) begin errors++; $display("[TB] FAIL reset_status: got %h expected 00000004", ReadDataM); end
  endtask

  task automatic test_ram();
    applyStimulus(1'b1, 32'h10, 32'h1111_1111);
    step();
    applyStimulus(1'b1, 32'h10, 32'hDEAD_BEEF);
    checks++; if (ReadDataM !== 32'h1111_1111) begin errors++; $display("[TB] FAIL ram_same_cycle_old: got %h expected 11111111", ReadDataM); end
    step();
    applyStimulus(1'b0, 32'h10, 32'd0);
    checks++; if (ReadDataM !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL ram_readback: got %h expected deadbeef", ReadDataM); end
    applyStimulus(1'b1, 32'h0, 32'hCAFE_0000);
    step();
    applyStimulus(1'b1, 32'h100, 32'h0000_0BAD);
    step();
    applyStimulus(1'b0, 32'h100, 32'd0);
    checks++; if (ReadDataM !== 32'd0) begin errors++; $display("[TB] FAIL ram_above_top: got %h expected 00000000", ReadDataM); end
    applyStimulus(1'b0, 32'h0, 32'd0);
    checks++; if (ReadDataM !== 32'hCAFE_0000) begin errors++; $display("[TB] FAIL ram_no_alias: got %h expected cafe0000", ReadDataM); end
    step();
    applyStimulus(1'b1, 32'hFC, 32'h0F0F_0F0F);
    step();
    applyStimulus(1'b0, 32'hFE, 32'd0);
    checks++; if (ReadDataM !== 32'h0F0F_0F0F) begin errors++; $display("[TB] FAIL ram_top_word: got %h expected 0f0f0f0f", ReadDataM); end
    applyStimulus(1'b0, 32'h8000_0020, 32'd0);
    checks++; if (ReadDataM !== 32'd0) begin errors++; $display("[TB] FAIL unmapped_read: got %h expected 00000000", ReadDataM); end
    step();
    applyStimulus(1'b0, ATx, 32'd0);
    checks++; if (ReadDataM !== 32'd0) begin errors++; $display("[TB] FAIL txdata_read: got %h expected 00000000", ReadDataM); end
    step();
  endtask

  task automatic test_counter();
    doReset();
    applyStimulus(1'b0, ACycle, 32'd0);
    checks++; if (ReadDataM !== 32'd0) begin errors++; $display("[TB] FAIL cycle_0: got %0d expected 0", ReadDataM); end
    step();
    applyStimulus(1'b0, ACycle, 32'd0);
    checks++; if (ReadDataM !== 32'd1) begin errors++; $display("[TB] FAIL cycle_1: got %0d expected 1", ReadDataM); end
    for (int i = 0; i < 4; i++) step();
    applyStimulus(1'b1, ACycle, 32'h1234_5678);
    checks++; if (ReadDataM !== 32'd5) begin errors++; $display("[TB] FAIL cycle_5: got %0d expected 5", ReadDataM); end
    step();
    applyStimulus(1'b1, AGpio, 32'h0000_1234);
    checks++; if (ReadDataM !== 32'h0000_1234 && gpio_out !== 32'd0) begin errors++; $display("[TB] FAIL gpio_pre: got %h expected 00000000", gpio_out); end
    applyStimulus(1'b1, AGpio, 32'h0000_1234);
    step();
    applyStimulus(1'b0, ACycle, 32'd0);
    checks++; if (ReadDataM !== 32'd7) begin errors++; $display("[TB] FAIL cycle_write_ignored: got %0d expected 7", ReadDataM); end
    checks++; if (gpio_out !== 32'h0000_1234) begin errors++; $display("[TB] FAIL gpio_before_reset: got %h expected 00001234", gpio_out); end
    reset = 1'b1;
    step();
    applyStimulus(1'b0, ACycle, 32'd0);
    checks++; if (ReadDataM !== 32'd0) begin errors++; $display("[TB] FAIL midreset_cycle: got %0d expected 0", ReadDataM); end
    checks++; if (gpio_out !== 32'd0) begin errors++; $display("[TB] FAIL midreset_gpio: got %h expected 00000000", gpio_out); end
    applyStimulus(1'b0, 32'h10, 32'd0);
    checks++; if (ReadDataM !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL midreset_ram_kept: got %h expected deadbeef", ReadDataM); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_timer();
    doReset();
    applyStimulus(1'b1, ACmp, 32'd20);
    step();
    while (cyc < 20) begin
      applyStimulus(1'b0, ACycle, 32'd0);
      step();
    end
    applyStimulus(1'b0, ACycle, 32'd0);
    checks++; if (ReadDataM !== 32'd20) begin errors++; $display("[TB] FAIL timer_cycle20: got %0d expected 20", ReadDataM); end
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("[TB] FAIL timer_before_match: got %b expected 0", timer_irq); end
    step();
    checks++; if (timer_irq !== 1'b1) begin errors++; $display("[TB] FAIL timer_rise: got %b expected 1", timer_irq); end
    step();
    step();
    checks++; if (timer_irq !== 1'b1) begin errors++; $display("[TB] FAIL timer_sticky: got %b expected 1", timer_irq); end
    applyStimulus(1'b1, AStatus, 32'h0000_0001);
    step();
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("[TB] FAIL timer_w1c: got %b expected 0", timer_irq); end
    applyStimulus(1'b0, AStatus, 32'd0);
    checks++; if (ReadDataM !== 32'h0000_0004) begin errors++; $display("[TB] FAIL timer_status_clear: got %h expected 00000004", ReadDataM); end
    applyStimulus(1'b1, ACmp, 32'd30);
    step();
    while (cyc < 30) begin
      applyStimulus(1'b0, ACycle, 32'd0);
      step();
    end
    applyStimulus(1'b1, AStatus, 32'h0000_0001);
    step();
    checks++; if (timer_irq !== 1'b1) begin errors++; $display("[TB] FAIL timer_set_wins: got %b expected 1", timer_irq); end
    applyStimulus(1'b0, AStatus, 32'd0);
    checks++; if (ReadDataM !== 32'h0000_0005) begin errors++; $display("[TB] FAIL timer_status_set: got %h expected 00000005", ReadDataM); end
    step();
  endtask

  task automatic test_fifo_fill();
    logic [7:0] expB;
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, ATx, 32'h41 + 32'(i));
      if (i == 0) begin
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL fifo_valid_pre: got %b expected 0", tx_valid); end
      end
      step();
      if (i == 0) begin
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin errors++; $display("[TB] FAIL fifo_first_push: got valid=%b data=%h expected valid=1 data=41", tx_valid, tx_data); end
      end
    end
    applyStimulus(1'b0, AStatus, 32'd0);
    checks++; if (ReadDataM !== 32'h0000_0062) begin errors++; $display("[TB] FAIL fifo_full_status: got %h expected 00000062", ReadDataM); end
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expB = 8'h41 + 8'(i);
      checks++; if (tx_valid !== 1'b1 || tx_data !== expB) begin errors++; $display("[TB] FAIL fifo_drain_%0d: got valid=%b data=%h expected valid=1 data=%h", i, tx_valid, tx_data, expB); end
      step();
    end
    checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("[TB] FAIL fifo_drained: got valid=%b data=%h expected valid=0 data=00", tx_valid, tx_data); end
    checks++; if (ReadDataM !== 32'h0000_0044) begin errors++; $display("[TB] FAIL fifo_empty_ovf_status: got %h expected 00000044", ReadDataM); end
    applyStimulus(1'b1, AStatus, 32'h0000_0040);
    step();
    applyStimulus(1'b0, AStatus, 32'd0);
    checks++; if (ReadDataM !== 32'h0000_0004) begin errors++; $display("[TB] FAIL fifo_ovf_w1c: got %h expected 00000004", ReadDataM); end
    step();
    applyStimulus(1'b1, ATx, 32'h0000_0077);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL fifo_no_bypass: got %b expected 0", tx_valid); end
    step();
    applyStimulus(1'b0, AStatus, 32'd0);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h77) begin errors++; $display("[TB] FAIL fifo_push_ready: got valid=%b data=%h expected valid=1 data=77", tx_valid, tx_data); end
    step();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL fifo_single_pop: got %b expected 0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] expQ [4];
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, ATx, 32'h41 + 32'(i));
      step();
    end
    applyStimulus(1'b0, AStatus, 32'd0);
    checks++; if (ReadDataM !== 32'h0000_0022) begin errors++; $display("[TB] FAIL b2b_full: got %h expected 00000022", ReadDataM); end
    tx_ready = 1'b1;
    applyStimulus(1'b1, ATx, 32'h0000_0055);
    checks++; if (tx_data !== 8'h41) begin errors++; $display("[TB] FAIL b2b_head: got %h expected 41", tx_data); end
    step();
    applyStimulus(1'b0, AStatus, 32'd0);
    checks++; if (ReadDataM !== 32'h0000_0022) begin errors++; $display("[TB] FAIL b2b_count_kept: got %h expected 00000022", ReadDataM); end
    expQ[0] = 8'h42; expQ[1] = 8'h43; expQ[2] = 8'h44; expQ[3] = 8'h55;
    for (int i = 0; i < 4; i++) begin
      checks++; if (tx_valid !== 1'b1 || tx_data !== expQ[i]) begin errors++; $display("[TB] FAIL b2b_drain_%0d: got valid=%b data=%h expected valid=1 data=%h", i, tx_valid, tx_data, expQ[i]); end
      step();
    end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_empty: got %b expected 0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_gpio();
    doReset();
    applyStimulus(1'b1, AGpio, 32'hA5A5_0F0F);
    checks++; if (gpio_out !== 32'd0) begin errors++; $display("[TB] FAIL gpio_before_edge: got %h expected 00000000", gpio_out); end
    step();
    checks++; if (gpio_out !== 32'hA5A5_0F0F) begin errors++; $display("[TB] FAIL gpio_after_edge: got %h expected a5a50f0f", gpio_out); end
    applyStimulus(1'b0, AGpio, 32'd0);
    checks++; if (ReadDataM !== 32'hA5A5_0F0F) begin errors++; $display("[TB] FAIL gpio_readback: got %h expected a5a50f0f", ReadDataM); end
    step();
  endtask

  // Scenario sequence, then the one summary line
  initial begin
    test_reset();
    test_ram();
    test_counter();
    test_timer();
    test_fifo_fill();
    test_back_to_back();
    test_gpio();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_mmio.md
# dmem_mmio

Data-side memory responder for the pipelined RISC-V core: it answers the core's Memory-stage load/store requests. It contains a word-addressed data RAM plus a small memory-mapped peripheral set: a GPIO output register, a free-running cycle counter, a compare timer with a sticky flag, and a byte transmit FIFO with a valid/ready drain port. It sits outside the core at the top level, connected to the core's `ALUResultM`, `WriteDataM`, `MemWriteM` and `ReadDataM`.

## Interface
- `RAM_WORDS`, default 64: data RAM depth in 32-bit words; must be a power of two, 64 or more.
- `FIFO_DEPTH`, default 4: TX FIFO entries; must be 2 or 4.

Ports:
- `clk`  in  1  clock; one clock domain; everything samples on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `MemWriteM`  in  1  store strobe from the core's M stage.
- `ALUResultM`  in  32  byte address; bits [1:0] are ignored.
- `WriteDataM`  in  32  store data.
- `ReadDataM`  out  32  load data; combinational from the address.
- `gpio_out`  out  32  GPIO register value.
- `timer_irq`  out  1  equals the timer flag.
- `tx_data`  out  8  FIFO head byte; 0 when the FIFO is empty.
- `tx_valid`  out  1  FIFO not empty.
- `tx_ready`  in  1  consumer accepts the head byte.

## Operation
- Word address is `wa = ALUResultM[31:2]`. Address map:
  - `0x0000_0000` to `RAM_WORDS*4-1`: RAM.
  - `0x8000_0000` GPIO: read/write.
  - `0x8000_0004` CYCLE: read-only; writes are ignored.
  - `0x8000_0008` TIMER_CMP: read/write.
  - `0x8000_000C` STATUS: bit0 timer flag (W1C); bit1 full; bit2 empty; bits[5:3] count; bit6 overflow (W1C); all other bits read 0.
  - `0x8000_0010` TX_DATA: a write pushes `WriteDataM[7:0]`; reads return 0.
  - Any other address: reads return 0; writes are ignored.
- RAM has no reset. Contents are X until written.
- Cycle counter: +1 every cycle; wraps from 0xFFFF_FFFF to 0.
- Timer flag: set at the edge where the pre-edge cycle counter equals TIMER_CMP.
  - Cleared by a STATUS write with bit0=1.
  - If set and clear happen in the same cycle, set wins.
- FIFO push is accepted when count < FIFO_DEPTH, or when a pop occurs in the same cycle.
  - A rejected push drops the byte and sets overflow. Overflow is cleared by a STATUS write with bit6=1; if set and clear coincide, set wins.
- FIFO pop occurs when `tx_valid & tx_ready`.
- With a simultaneous push and pop, count is unchanged and order is preserved. Pushing into an empty FIFO while `tx_ready` is high does not bypass: the byte appears on `tx_data` the next cycle.
- Reset values:
  - `gpio_out` = 0, CYCLE = 0, TIMER_CMP = 0xFFFF_FFFF.
  - Timer flag = 0, overflow = 0.
  - FIFO empty, so `tx_valid` = 0 and `tx_data` = 0.
- Reset mid-operation flushes the FIFO contents. RAM is untouched.

## Timing
- Reads have zero latency: `ReadDataM` follows `ALUResultM` combinationally in the same cycle.
- Writes commit at the rising edge where `MemWriteM` = 1.
  - A read of the same address in that cycle returns the old value.
  - A read in the next cycle returns the new value.
- A STATUS or CYCLE read returns the register's pre-edge value for that cycle.
- `tx_valid` rises one cycle after the accepted push into an empty FIFO. The head advances one cycle after a pop.
- `timer_irq` is registered: it rises the cycle after the match edge.

## Test plan
- RAM write/read: store 0xDEADBEEF to 0x10, then load 0x10 next cycle → 0xDEADBEEF. A same-cycle load during the store → old value. A load from 0x8000_0020 → 0.
- Counter and reset: after reset, read CYCLE at cycles 0, 1, 5 → 0, 1, 5. Assert `reset` mid-run → CYCLE = 0 the next cycle and `gpio_out` = 0.
- Timer: write TIMER_CMP = 20 → `timer_irq` = 1 from the cycle after CYCLE = 20 and stays high. W1C to STATUS → clears. Clear coinciding with a match → flag stays 1.
- FIFO fill: hold `tx_ready` = 0 and push 0x41..0x45 → STATUS = full, count 4, overflow = 1, and 0x45 is dropped. Raise `tx_ready` → 0x41, 0x42, 0x43, 0x44 drain one per cycle, then `tx_valid` = 0.
- FIFO full with simultaneous push and pop: push 0x55 while full and popping → accepted, count stays 4, no overflow, 0x55 drains last.
- GPIO: write 0xA5A5_0F0F → `gpio_out` changes at the next edge; a readback returns the same value.
